pattern_serializer: RTL

Parallel-to-serial front end that sits directly upstream of the pattern detector. It accepts WIDTH-bit words over a valid/ready handshake, buffers them in a small FIFO, and emits them LSB-first as a one-bit-per-cycle stream with a qualifying valid. That stream drives the detector's `valid`/`in` inputs, so a captured or generated word sequence can be replayed deterministically into the detector.

---
 rtl/pser_pkg.sv | 11 +
 rtl/pser_fifo.sv | 55 +++++
 rtl/pattern_serializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pser_pkg.sv
// Shared types and constants for the pattern serializer slice.
package pser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } pser_state_t;

   localparam int STATS_W = 16;

endpackage

// File: rtl/pser_fifo.sv
// Word FIFO feeding the serializer's shifter.
// Full/empty are derived from level; pointers wrap naturally.
module pser_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPush = push && (level < LVL_W'(DEPTH)) && !flush;
   assign doPop  = pop && (level != '0) && !flush;
   assign dout   = mem[rdPtr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage has no reset; only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end for the pattern detector: FIFO-buffered words
// emitted LSB-first. Define PSER_STATS_EN to add the word_cnt output.
module pattern_serializer
   import pser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       s_ready,
   input  logic                       hold,
   input  logic                       flush,
   output logic                       m_valid,
   output logic                       m_bit,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       busy
`ifdef PSER_STATS_EN
   ,
   output logic [STATS_W-1:0]         word_cnt
`endif
);

   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH-1);

   pser_state_t      state;
   pser_state_t      stateNext;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bitCnt;
   logic [WIDTH-1:0] fifoDout;
   logic             pop;
   logic             shiftEn;
   logic             wordDone;
   logic             mValidNext;
   logic             mBitNext;

   assign s_ready = (level < LVL_W'(DEPTH)) && !flush;

   pser_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid && s_ready),
      .pop   (pop),
      .flush (flush),
      .din   (s_data),
      .dout  (fifoDout),
      .level (level)
   );

   // Reloading on the last bit keeps back-to-back words free of bubbles.
   always_comb begin
      stateNext  = state;
      pop        = 1'b0;
      shiftEn    = 1'b0;
      wordDone   = 1'b0;
      mValidNext = 1'b0;
      mBitNext   = m_bit;
      if (flush) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if ((level != '0) && !hold) begin
                  pop       = 1'b1;
                  stateNext = SHIFT;
               end
            end
            SHIFT: begin
               if (!hold) begin
                  mValidNext = 1'b1;
                  mBitNext   = shreg[0];
                  shiftEn    = 1'b1;
                  if (bitCnt == LAST_BIT) begin
                     wordDone = 1'b1;
                     if (level != '0) pop = 1'b1;
                     else stateNext = IDLE;
                  end
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bitCnt  <= '0;
         m_valid <= 1'b0;
         m_bit   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         m_valid <= mValidNext;
         m_bit   <= mBitNext;
         busy    <= (stateNext == SHIFT);
         if (flush) begin
            shreg  <= '0;
            bitCnt <= '0;
         end else if (pop) begin
            shreg  <= fifoDout;
            bitCnt <= '0;
         end else if (shiftEn) begin
            shreg  <= shreg >> 1;
            bitCnt <= wordDone ? '0 : bitCnt + CNT_W'(1);
         end
      end
   end

`ifdef PSER_STATS_EN
   // Counts completed words only; flush never touches it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          word_cnt <= '0;
      else if (wordDone) word_cnt <= word_cnt + STATS_W'(1);
   end
`endif

endmodule
